microcode_sequencer: RTL and testbench
======================================

// Module: microcode_sequencer
// PURPOSE
// Parametrised micro-PC sequencer replacing the fixed 3-phase counter in the CPU control path.
// Dispatches each fetched opcode into an external synchronous micro-ROM.
// Steps through variable-length micro-sequences using NEXT/JUMP/COND/END fields, with memory wait-states and a runaway guard.
// Sits between instruction fetch (opcode handshake) and the datapath (ctrl word).
// PARAMETERS
// UW         56  micro-word width
// UADDR_W    10  micro-ROM address width
// OPC_W       8  opcode width
// STEP_BITS   2  dispatch address = opcode << STEP_BITS; OPC_W+STEP_BITS <= UADDR_W
// MAX_STEPS  32  max micro-steps per instruction (2..255); exceeding it is a fault
// localparam CTRL_W = UW-3-UADDR_W
// PORTS
// clk           in   1        clock
// reset_n       in   1        asynchronous, active-low reset
// rdy           in   1        global ready; low freezes all state
// opcode_valid  in   1        fetch offers opcode
// opcode        in   OPC_W    opcode to dispatch
// opcode_ready  out  1        sequencer accepts opcode this cycle
// rom_addr      out  UADDR_W  micro-ROM read address (ROM registers it; data next cycle)
// rom_data      in   UW       micro-word for rom_addr of previous cycle
// mem_ack       in   1        memory completed current access
// cond          in   1        branch condition (flag selected by datapath)
// ctrl          out  CTRL_W   control field rom_data[UW-1:3+UADDR_W]; 0 when ctrl_valid=0
// ctrl_valid    out  1        ctrl applies this cycle
// instr_done    out  1        final micro-step of instruction completes this cycle
// step_count    out  8        micro-steps completed in current instruction
// fault         out  1        one-cycle pulse: MAX_STEPS exceeded, instruction aborted
// BEHAVIOUR
// Micro-word fields:
//   [1:0] seq_op: 00 NEXT, 01 END, 10 JUMP, 11 COND
//   [2] wait_mem
//   [3+UADDR_W-1:3] target
// States: IDLE, EXEC. Regs: state, uaddr_q, step_count, fault.
// Reset (async): state=IDLE, uaddr_q=0, step_count=0, fault=0. rom_addr=0, ctrl=0, ctrl_valid=0, instr_done=0.
// IDLE:
//   - opcode_ready = rdy.
//   - On opcode_valid&&rdy: rom_addr = opcode<<STEP_BITS (comb.), uaddr_q <= that address, step_count <= 0, go EXEC.
//   - Otherwise rom_addr = uaddr_q.
// EXEC: rom_data is valid for uaddr_q. ctrl_valid = rdy.
//   adv = rdy && (!wait_mem || mem_ack). On adv, step_count++ and:
//     NEXT: uaddr_q+1, modulo 2^UADDR_W (wraps to 0).
//     JUMP: target.
//     COND: cond ? target : uaddr_q+1.
//     END:  instr_done=1, opcode_ready=1.
//       opcode_valid same cycle -> dispatch as in IDLE, stay EXEC, step_count <= 0 (zero-bubble back-to-back).
//       Otherwise go IDLE.
//   rom_addr = adv ? next address : uaddr_q. The ROM re-reads during stalls, so rom_data stays stable.
//   Stall (wait_mem && !mem_ack, or !rdy): ctrl held, no state change, no done.
//   rdy=0: ctrl_valid=0, ctrl=0, opcode_ready=0, no register updates; mem_ack ignored.
// Runaway guard:
//   - adv with seq_op != END when step_count == MAX_STEPS-1: next cycle fault=1 (one cycle), state=IDLE, step_count=0.
//   - instr_done not asserted.
// step_count after END is held until next dispatch.
// Latency: dispatch to first ctrl_valid = 1 cycle; an N-step instruction with no stalls occupies N EXEC cycles.
// reset_n low mid-instruction: immediate abort to reset values; no done, no fault.
// TESTING
// - Reset during EXEC with wait_mem stall -> all outputs 0 same cycle, state IDLE, opcode_ready=rdy after release.
// - opcode 0xA9 (STEP_BITS=2): rom_addr=0x2A4 at dispatch; NEXT,NEXT,END at 0x2A4..0x2A6 -> ctrl_valid 3 cycles, instr_done on 3rd, step_count=3.
// - wait_mem on step 2, mem_ack after 4 cycles -> rom_addr held 0x2A5, ctrl stable 5 cycles, then advance.
// - COND at 0x010, target 0x100: cond=1 -> rom_addr 0x100; cond=0 -> 0x011. NEXT at 0x3FF -> 0x000.
// - END with opcode_valid (0x4C) same cycle -> instr_done=1, opcode_ready=1, next cycle ctrl from 0x130, no bubble. rdy=0 mid-step freezes everything.
// - MAX_STEPS=16, JUMP-to-self loop -> fault pulses once after 16th step, state IDLE, instr_done never asserted.

Source files
------------

// File: rtl/microcode_sequencer.sv
// Micro-PC sequencer: dispatches opcodes into an external synchronous micro-ROM and walks
// NEXT/JUMP/COND/END micro-sequences with memory wait-states and a runaway-step guard.
module microcode_sequencer #(
  parameter int unsigned UW        = 56,
  parameter int unsigned UADDR_W   = 10,
  parameter int unsigned OPC_W     = 8,
  parameter int unsigned STEP_BITS = 2,
  parameter int unsigned MAX_STEPS = 32,
  localparam int unsigned CTRL_W   = UW - 3 - UADDR_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rdy_i,
  input  logic               opcode_valid_i,
  input  logic [OPC_W-1:0]   opcode_i,
  output logic               opcode_ready_o,
  output logic [UADDR_W-1:0] rom_addr_o,
  input  logic [UW-1:0]      rom_data_i,
  input  logic               mem_ack_i,
  input  logic               cond_i,
  output logic [CTRL_W-1:0]  ctrl_o,
  output logic               ctrl_valid_o,
  output logic               instr_done_o,
  output logic [7:0]         step_count_o,
  output logic               fault_o
);

  localparam logic [1:0] SeqNext = 2'b00;
  localparam logic [1:0] SeqEnd  = 2'b01;
  localparam logic [1:0] SeqJump = 2'b10;
  localparam logic [1:0] SeqCond = 2'b11;

  localparam logic [7:0] LastStep = 8'(MAX_STEPS - 1);

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  state_e             state_q, state_d;
  logic [UADDR_W-1:0] uaddr_q, uaddr_d;
  logic [7:0]         step_q, step_d;
  logic               fault_q, fault_d;

  logic [1:0]         seq_op;
  logic               wait_mem;
  logic [UADDR_W-1:0] target;
  logic [UADDR_W-1:0] disp_addr;
  logic [UADDR_W-1:0] incr_addr;
  logic               live_rdy;
  logic               adv;
  logic               dispatch;

  assign seq_op    = rom_data_i[1:0];
  assign wait_mem  = rom_data_i[2];
  assign target    = rom_data_i[3 +: UADDR_W];
  assign disp_addr = UADDR_W'(opcode_i) << STEP_BITS;
  assign incr_addr = uaddr_q + UADDR_W'(1);

  // Gating with reset_n forces every combinational output to zero while reset is held.
  assign live_rdy  = rdy_i & reset_n;

  always_comb begin
    state_d        = state_q;
    uaddr_d        = uaddr_q;
    step_d         = step_q;
    fault_d        = 1'b0;
    rom_addr_o     = uaddr_q;
    opcode_ready_o = 1'b0;
    ctrl_valid_o   = 1'b0;
    ctrl_o         = '0;
    instr_done_o   = 1'b0;
    adv            = 1'b0;
    dispatch       = 1'b0;

    unique case (state_q)
      StIdle: begin
        opcode_ready_o = live_rdy;
        dispatch       = live_rdy & opcode_valid_i;
      end
      StExec: begin
        ctrl_valid_o = live_rdy;
        if (live_rdy) begin
          ctrl_o = rom_data_i[UW-1 -: CTRL_W];
        end
        adv = live_rdy & (~wait_mem | mem_ack_i);
        if (adv) begin
          step_d = step_q + 8'd1;
          unique case (seq_op)
            SeqNext: uaddr_d = incr_addr;
            SeqJump: uaddr_d = target;
            SeqCond: uaddr_d = cond_i ? target : incr_addr;
            SeqEnd: begin
              instr_done_o   = 1'b1;
              opcode_ready_o = 1'b1;
              dispatch       = opcode_valid_i;
              if (!opcode_valid_i) begin
                state_d = StIdle;
              end
            end
            default: uaddr_d = uaddr_q;
          endcase
          // Runaway guard: a non-END step that would exceed MAX_STEPS aborts the instruction.
          if (seq_op != SeqEnd && step_q == LastStep) begin
            state_d = StIdle;
            uaddr_d = uaddr_q;
            step_d  = '0;
            fault_d = 1'b1;
          end
          rom_addr_o = uaddr_d;
        end
      end
      default: state_d = StIdle;
    endcase

    if (dispatch) begin
      state_d    = StExec;
      uaddr_d    = disp_addr;
      step_d     = '0;
      rom_addr_o = disp_addr;
    end
  end

  // Next-state equals current state whenever rdy_i is low, so no explicit enable is needed;
  // fault_q is a pulse and always clears after one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      uaddr_q <= '0;
      step_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      uaddr_q <= uaddr_d;
      step_q  <= step_d;
      fault_q <= fault_d;
    end
  end

  assign step_count_o = step_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: bench-side micro-ROM, an instruction-level model
// checked every cycle, and literal expectations for the key scenarios.
module tb_microcode_sequencer;
  localparam int unsigned UW        = 56;
  localparam int unsigned UADDR_W   = 10;
  localparam int unsigned OPC_W     = 8;
  localparam int unsigned STEP_BITS = 2;
  localparam int unsigned MAX_STEPS = 16;
  localparam int unsigned CTRL_W    = UW - 3 - UADDR_W;

  localparam logic [1:0] OpNext = 2'b00;
  localparam logic [1:0] OpEnd  = 2'b01;
  localparam logic [1:0] OpJump = 2'b10;
  localparam logic [1:0] OpCond = 2'b11;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              rdy = 1'b0;
  logic              ov = 1'b0;
  logic [OPC_W-1:0]  opc = '0;
  logic              mem_ack = 1'b0;
  logic              cond = 1'b0;
  logic              opcode_ready;
  logic [UADDR_W-1:0] rom_addr;
  logic [UW-1:0]     rom_data = '0;
  logic [CTRL_W-1:0] ctrl;
  logic              ctrl_valid;
  logic              instr_done;
  logic [7:0]        step_count;
  logic              fault;

  logic [UW-1:0]     rom [1024];

  int errors = 0;
  int checks = 0;

  // Instruction-level model state
  bit                m_busy = 1'b0;
  logic [UADDR_W-1:0] m_pc = '0;
  int                m_steps = 0;
  bit                m_fault = 1'b0;

  microcode_sequencer #(
    .UW        (UW),
    .UADDR_W   (UADDR_W),
    .OPC_W     (OPC_W),
    .STEP_BITS (STEP_BITS),
    .MAX_STEPS (MAX_STEPS)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rdy_i          (rdy),
    .opcode_valid_i (ov),
    .opcode_i       (opc),
    .opcode_ready_o (opcode_ready),
    .rom_addr_o     (rom_addr),
    .rom_data_i     (rom_data),
    .mem_ack_i      (mem_ack),
    .cond_i         (cond),
    .ctrl_o         (ctrl),
    .ctrl_valid_o   (ctrl_valid),
    .instr_done_o   (instr_done),
    .step_count_o   (step_count),
    .fault_o        (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [UW-1:0] mk(input logic [CTRL_W-1:0] c, input logic [UADDR_W-1:0] t,
                                       input logic w, input logic [1:0] op);
    return {c, t, w, op};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare DUT against the model for the current inputs, then advance model.
  task automatic cyc();
    logic [UW-1:0]      w;
    logic [UADDR_W-1:0] nxt;
    logic [UADDR_W-1:0] addr;
    logic [CTRL_W-1:0]  c;
    bit r, adv, done, ready, disp, abort, cv;
    #1;
    if (!reset_n) begin
      m_busy = 1'b0; m_pc = '0; m_steps = 0; m_fault = 1'b0;
    end
    r = rdy && reset_n;
    w = rom[m_pc];
    ready = 0; done = 0; cv = 0; c = '0; adv = 0; abort = 0; disp = 0; nxt = m_pc;
    if (!m_busy) begin
      ready = r;
      disp  = r && ov;
    end else begin
      cv  = r;
      if (r) c = w[UW-1 -: CTRL_W];
      adv = r && (!w[2] || mem_ack);
      if (adv) begin
        case (w[1:0])
          OpNext: nxt = m_pc + 10'd1;
          OpJump: nxt = w[12:3];
          OpCond: nxt = cond ? w[12:3] : m_pc + 10'd1;
          default: begin done = 1; ready = 1; disp = ov; end
        endcase
        if (w[1:0] != OpEnd && m_steps == MAX_STEPS - 1) begin
          abort = 1;
          nxt   = m_pc;
        end
      end
    end
    addr = disp ? {opc, 2'b00} : nxt;
    chk("cyc_ctrl_valid", ctrl_valid, cv);
    chk("cyc_ctrl", ctrl, c);
    chk("cyc_instr_done", instr_done, done);
    chk("cyc_opcode_ready", opcode_ready, ready);
    chk("cyc_rom_addr", rom_addr, addr);
    chk("cyc_step_count", step_count, m_steps);
    chk("cyc_fault", fault, m_fault);
    @(posedge clk);
    m_fault = abort;
    if (disp) begin
      m_busy = 1; m_pc = addr; m_steps = 0;
    end else if (adv) begin
      if (abort) begin
        m_busy = 0; m_steps = 0;
      end else begin
        m_steps++;
        m_pc = nxt;
        if (done) m_busy = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    rom[10'h000] = mk(43'h0DD, 10'h000, 1'b0, OpEnd);
    rom[10'h2A4] = mk(43'h111, 10'h000, 1'b0, OpNext);
    rom[10'h2A5] = mk(43'h222, 10'h000, 1'b0, OpNext);
    rom[10'h2A6] = mk(43'h333, 10'h000, 1'b0, OpEnd);
    rom[10'h010] = mk(43'h0AA, 10'h100, 1'b0, OpCond);
    rom[10'h100] = mk(43'h0BB, 10'h000, 1'b0, OpEnd);
    rom[10'h011] = mk(43'h0CC, 10'h000, 1'b0, OpEnd);
    for (int i = 0; i < 4; i++) rom[10'h3FC + i] = mk(43'h3F0 + 43'(i), 10'h000, 1'b0, OpNext);
    rom[10'h130] = mk(43'h444, 10'h000, 1'b0, OpNext);
    rom[10'h131] = mk(43'h555, 10'h000, 1'b0, OpEnd);
    rom[10'h0C0] = mk(43'h666, 10'h0C0, 1'b0, OpJump);

    // Reset values
    #2 reset_n = 1'b0;
    @(negedge clk);
    rdy = 1'b1;
    #1;
    chk("reset_rom_addr", rom_addr, 10'h000);
    chk("reset_ctrl_valid", ctrl_valid, 1'b0);
    chk("reset_step_count", step_count, 8'd0);
    chk("reset_fault", fault, 1'b0);
    cyc(); cyc();
    reset_n = 1'b1;
    #1 chk("release_ready", opcode_ready, 1'b1);
    cyc();

    // Opcode 0xA9: three steps NEXT,NEXT,END
    ov = 1'b1; opc = 8'hA9;
    #1 chk("a9_dispatch_addr", rom_addr, 10'h2A4);
    cyc();
    ov = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("a9_ctrl_valid", ctrl_valid, 1'b1);
      chk("a9_done", instr_done, (i == 2));
      cyc();
    end
    #1 chk("a9_step_count", step_count, 8'd3);
    cyc();

    // Wait-state on step 2, ack after 4 stalled cycles
    rom[10'h2A5] = mk(43'h222, 10'h000, 1'b1, OpNext);
    ov = 1'b1; opc = 8'hA9;
    cyc();
    ov = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1 chk("stall_addr", rom_addr, 10'h2A5);
      chk("stall_ctrl", ctrl, 43'h222);
      cyc();
    end
    mem_ack = 1'b1;
    #1 chk("ack_addr", rom_addr, 10'h2A6);
    chk("ack_ctrl", ctrl, 43'h222);
    cyc();
    mem_ack = 1'b0;
    cyc(); cyc();

    // COND taken / not taken
    for (int k = 0; k < 2; k++) begin
      ov = 1'b1; opc = 8'h04;
      cyc();
      ov = 1'b0; cond = (k == 0);
      #1 chk("cond_addr", rom_addr, (k == 0) ? 10'h100 : 10'h011);
      cyc();
      #1 chk("cond_end_ctrl", ctrl, (k == 0) ? 43'h0BB : 43'h0CC);
      cyc(); cyc();
    end
    cond = 1'b0;

    // NEXT at 0x3FF wraps to 0x000
    ov = 1'b1; opc = 8'hFF;
    #1 chk("wrap_dispatch_addr", rom_addr, 10'h3FC);
    cyc();
    ov = 1'b0;
    cyc(); cyc(); cyc();
    #1 chk("wrap_addr", rom_addr, 10'h000);
    cyc();
    #1 chk("wrap_end_done", instr_done, 1'b1);
    cyc(); cyc();

    // Back-to-back dispatch at END, then rdy freeze
    rom[10'h2A5] = mk(43'h222, 10'h000, 1'b0, OpNext);
    ov = 1'b1; opc = 8'hA9;
    cyc();
    ov = 1'b0;
    cyc(); cyc();
    ov = 1'b1; opc = 8'h4C;
    #1 chk("b2b_done", instr_done, 1'b1);
    chk("b2b_ready", opcode_ready, 1'b1);
    chk("b2b_addr", rom_addr, 10'h130);
    cyc();
    ov = 1'b0;
    #1 chk("b2b_ctrl_valid", ctrl_valid, 1'b1);
    chk("b2b_ctrl", ctrl, 43'h444);
    chk("b2b_steps", step_count, 8'd0);
    cyc();
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("frz_ctrl_valid", ctrl_valid, 1'b0);
      chk("frz_ctrl", ctrl, 43'h0);
      chk("frz_addr", rom_addr, 10'h131);
      chk("frz_steps", step_count, 8'd1);
      cyc();
    end
    rdy = 1'b1;
    #1 chk("frz_resume_done", instr_done, 1'b1);
    chk("frz_resume_ctrl", ctrl, 43'h555);
    cyc(); cyc();

    // Runaway JUMP-to-self loop
    ov = 1'b1; opc = 8'h30;
    cyc();
    ov = 1'b0;
    for (int i = 0; i < MAX_STEPS; i++) begin
      #1 chk("loop_done", instr_done, 1'b0);
      chk("loop_ctrl_valid", ctrl_valid, 1'b1);
      cyc();
    end
    #1 chk("fault_pulse", fault, 1'b1);
    chk("fault_steps", step_count, 8'd0);
    chk("fault_idle", ctrl_valid, 1'b0);
    cyc();
    #1 chk("fault_clear", fault, 1'b0);
    cyc();

    // Reset during a wait-state stall
    rom[10'h2A5] = mk(43'h222, 10'h000, 1'b1, OpNext);
    ov = 1'b1; opc = 8'hA9;
    cyc();
    ov = 1'b0;
    cyc(); cyc(); cyc();
    reset_n = 1'b0;
    #1 chk("rst_ctrl_valid", ctrl_valid, 1'b0);
    chk("rst_ctrl", ctrl, 43'h0);
    chk("rst_addr", rom_addr, 10'h000);
    chk("rst_steps", step_count, 8'd0);
    chk("rst_ready", opcode_ready, 1'b0);
    cyc();
    reset_n = 1'b1;
    #1 chk("rst_release_ready", opcode_ready, 1'b1);
    chk("rst_release_idle", ctrl_valid, 1'b0);
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
